// File: rtl/buscador_binario.sv
// ---------------------------------------------------------------------------
// buscador_binario
// Successive-approximation search controller for a WIDTH-bit magnitude
// comparator. Operand A of the comparator holds an unknown value. This block
// drives operand B (guess) and the comparator enable (cmp_on). It reads back
// the equal/less/greater flags and narrows a [lo, hi] window until the
// comparator reports equality. It flags any comparator response that is
// inconsistent with the current window.
//
// Parameters:
//   WIDTH        operand width; must match the comparator A/B width.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (has priority over start)
//   start        begin a search; sampled only in IDLE
//   cmp_equal    comparator A_equal_B   (hidden == guess)
//   cmp_less     comparator A_less_B    (hidden <  guess)
//   cmp_greater  comparator A_greater_B (hidden >  guess)
//   guess        drives comparator B
//   cmp_on       drives comparator turnON
//   busy         high from start acceptance through the DONE cycle
//   done         one-cycle completion pulse
//   found        recovered value; valid from done until the next start
//   error        search failed; held until the next accepted start
//   steps        number of probes used by the last search
//
// Configuration macro:
//   BUSCADOR_SETTLE_EN  when defined, every probe is preceded by a SETTLE
//                       cycle. In that cycle guess and cmp_on are driven but
//                       the flags are ignored, which suits registered
//                       comparators. steps still counts probes.
// ---------------------------------------------------------------------------
module buscador_binario #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    input  logic             cmp_greater,
    output logic [WIDTH-1:0] guess,
    output logic             cmp_on,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic             error,
    output logic [WIDTH:0]   steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
`ifdef BUSCADOR_SETTLE_EN
        ,
        S_SETTLE
`endif
    } state_t;

    // State that begins each probe: a settle cycle first, when enabled.
`ifdef BUSCADOR_SETTLE_EN
    localparam state_t PROBE_ENTRY = S_SETTLE;
`else
    localparam state_t PROBE_ENTRY = S_PROBE;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    // Midpoints are summed one bit wider so that hi = MAX_VAL cannot wrap.
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_sum;
    logic [WIDTH-1:0] up_mid;
    logic [WIDTH-1:0] dn_mid;

    assign up_sum = {1'b0, guess} + {1'b0, hi} + (WIDTH+1)'(1);
    assign dn_sum = {1'b0, lo} + {1'b0, guess} - (WIDTH+1)'(1);
    assign up_mid = WIDTH'(up_sum >> 1);
    assign dn_mid = WIDTH'(dn_sum >> 1);

    // Decode the comparator response for the current probe. Exactly one flag
    // is legal. A legal move that would step outside the window means the
    // comparator contradicts an earlier answer, so it counts as an error too.
    logic probe_hit;
    logic probe_up;
    logic probe_dn;
    logic probe_fail;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        probe_hit  = 1'b0;
        probe_up   = 1'b0;
        probe_dn   = 1'b0;
        probe_fail = 1'b0;
        unique case ({cmp_equal, cmp_less, cmp_greater})
            3'b100:  probe_hit = 1'b1;
            3'b001:  if (guess == hi) probe_fail = 1'b1; else probe_up = 1'b1;
            3'b010:  if (guess == lo) probe_fail = 1'b1; else probe_dn = 1'b1;
            default: probe_fail = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every right-hand
    // side reads the value from before this edge.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // and takes effect only on a rising edge.
        if (rst) begin
            state  <= S_IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            cmp_on <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= '0;
            error  <= 1'b0;
            steps  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        lo     <= '0;
                        hi     <= MAX_VAL;
                        guess  <= MAX_VAL >> 1;
                        steps  <= '0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        cmp_on <= 1'b1;
                        state  <= PROBE_ENTRY;
                    end
                end

`ifdef BUSCADOR_SETTLE_EN
                // guess and cmp_on are already driven; give the comparator
                // a cycle before its flags are trusted.
                S_SETTLE: state <= S_PROBE;
`endif

                S_PROBE: begin
                    steps <= steps + 1'b1;
                    if (probe_up) begin
                        lo    <= guess + 1'b1;
                        guess <= up_mid;
                        state <= PROBE_ENTRY;
                    end else if (probe_dn) begin
                        hi    <= guess - 1'b1;
                        guess <= dn_mid;
                        state <= PROBE_ENTRY;
                    end else begin
                        found  <= probe_hit ? guess : '0;
                        error  <= probe_fail;
                        done   <= 1'b1;
                        cmp_on <= 1'b0;
                        state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buscador_binario.sv
// ---------------------------------------------------------------------------
// tb_buscador_binario
// Self-checking bench for buscador_binario (WIDTH=2). A behavioural
// comparator answers each guess and can be switched to faulty modes. Table
// vectors give the expected guess sequence and the final result of each
// search. The final result is pushed to a scoreboard queue when the search
// starts, and it is popped and compared when done rises. Hand-written
// sequences cover reset priority, reset mid-search and the fact that start is
// ignored while busy.
// ---------------------------------------------------------------------------
module tb_buscador_binario;

    localparam int WIDTH = 2;
`ifdef BUSCADOR_SETTLE_EN
    localparam int PC = 2;   // cycles per probe
`else
    localparam int PC = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cmp_equal;
    logic             cmp_less;
    logic             cmp_greater;
    logic [WIDTH-1:0] guess;
    logic             cmp_on;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] found;
    logic             error;
    logic [WIDTH:0]   steps;

    always #5 clk = ~clk;

    buscador_binario #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmp_equal  (cmp_equal),
        .cmp_less   (cmp_less),
        .cmp_greater(cmp_greater),
        .guess      (guess),
        .cmp_on     (cmp_on),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .error      (error),
        .steps      (steps)
    );

    // Comparator model with fault modes.
    typedef enum int {M_NORMAL, M_ZERO, M_GREATER, M_LESS, M_MULTI} mode_t;
    mode_t            mode;
    logic [WIDTH-1:0] hidden;

    always_comb begin
        cmp_equal   = 1'b0;
        cmp_less    = 1'b0;
        cmp_greater = 1'b0;
        case (mode)
            M_NORMAL: begin
                cmp_equal   = cmp_on && (hidden == guess);
                cmp_less    = cmp_on && (hidden <  guess);
                cmp_greater = cmp_on && (hidden >  guess);
            end
            M_GREATER: cmp_greater = cmp_on;
            M_LESS:    cmp_less    = cmp_on;
            M_MULTI: begin
                cmp_equal   = cmp_on;
                cmp_greater = cmp_on;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0]      hidden;
        mode_t                 mode;
        bit                    hold_start;
        int                    n_guess;
        logic [3:0][WIDTH-1:0] guesses;   // element 0 is the first probe
        logic [WIDTH-1:0]      exp_found;
        logic                  exp_error;
        logic [WIDTH:0]        exp_steps;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] found;
        logic             error;
        logic [WIDTH:0]   steps;
        int               latency;
    } result_t;

    result_t sb_q[$];
    vec_t    vecs[9];
    int      n_cmp  = 0;
    int      n_fail = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_guess"},  32'(guess),  0);
        check({tag, "_cmp_on"}, 32'(cmp_on), 0);
        check({tag, "_busy"},   32'(busy),   0);
        check({tag, "_done"},   32'(done),   0);
        check({tag, "_found"},  32'(found),  0);
        check({tag, "_error"},  32'(error),  0);
        check({tag, "_steps"},  32'(steps),  0);
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] h, input mode_t m,
                                input bit hs, input int n, input logic [7:0] g,
                                input logic [WIDTH-1:0] f, input logic e,
                                input logic [WIDTH:0] s);
        vec_t v;
        v.hidden     = h;
        v.mode       = m;
        v.hold_start = hs;
        v.n_guess    = n;
        v.guesses    = g;
        v.exp_found  = f;
        v.exp_error  = e;
        v.exp_steps  = s;
        return v;
    endfunction

    // One complete search: drive start, follow the probes cycle by cycle,
    // and score the result when done rises.
    task automatic run_search(input int id, input vec_t v);
        result_t exp;
        int      cyc;
        int      idx;
        bit      seen;
        string   tag;
        tag    = $sformatf("v%0d", id);
        mode   = v.mode;
        hidden = v.hidden;
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        start = 1'b1;
        exp.found   = v.exp_found;
        exp.error   = v.exp_error;
        exp.steps   = v.exp_steps;
        exp.latency = v.n_guess * PC + 1;
        sb_q.push_back(exp);
        @(posedge clk); #1;           // start accepted; first probe cycle
        if (!v.hold_start) start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 20) begin
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 1, 0);
                end else begin
                    exp = sb_q.pop_front();
                    check({tag, "_found"},   32'(found), 32'(exp.found));
                    check({tag, "_error"},   32'(error), 32'(exp.error));
                    check({tag, "_steps"},   32'(steps), 32'(exp.steps));
                    check({tag, "_latency"}, 32'(cyc),   32'(exp.latency));
                    check({tag, "_done_busy"},   32'(busy),   1);
                    check({tag, "_done_cmp_on"}, 32'(cmp_on), 0);
                end
            end else begin
                idx = (cyc - 1) / PC;
                check({tag, "_probe_busy"},   32'(busy),   1);
                check({tag, "_probe_cmp_on"}, 32'(cmp_on), 1);
                check({tag, "_probe_error"},  32'(error),  0);
                if (idx < v.n_guess)
                    check($sformatf("%s_guess%0d", tag, idx), 32'(guess),
                          32'(v.guesses[idx]));
                else
                    check({tag, "_probe_count"}, 32'(idx), 32'(v.n_guess - 1));
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            sb_q.delete();
        end else begin
            @(posedge clk); #1;
            check({tag, "_after_done"},  32'(done),  0);
            check({tag, "_after_busy"},  32'(busy),  0);
            check({tag, "_hold_found"},  32'(found), 32'(v.exp_found));
            check({tag, "_hold_error"},  32'(error), 32'(v.exp_error));
            check({tag, "_hold_steps"},  32'(steps), 32'(v.exp_steps));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          hidden mode       hold n  guesses (g3,g2,g1,g0)        found err steps
        vecs[0] = mk(2'd1, M_NORMAL,  0,   1, {2'd0, 2'd0, 2'd0, 2'd1}, 2'd1, 0, 3'd1);
        vecs[1] = mk(2'd3, M_NORMAL,  0,   3, {2'd0, 2'd3, 2'd2, 2'd1}, 2'd3, 0, 3'd3);
        vecs[2] = mk(2'd0, M_NORMAL,  0,   2, {2'd0, 2'd0, 2'd0, 2'd1}, 2'd0, 0, 3'd2);
        vecs[3] = mk(2'd2, M_ZERO,    0,   1, {2'd0, 2'd0, 2'd0, 2'd1}, 2'd0, 1, 3'd1);
        vecs[4] = mk(2'd0, M_GREATER, 0,   3, {2'd0, 2'd3, 2'd2, 2'd1}, 2'd0, 1, 3'd3);
        vecs[5] = mk(2'd2, M_NORMAL,  0,   2, {2'd0, 2'd0, 2'd2, 2'd1}, 2'd2, 0, 3'd2);
        vecs[6] = mk(2'd3, M_LESS,    0,   2, {2'd0, 2'd0, 2'd0, 2'd1}, 2'd0, 1, 3'd2);
        vecs[7] = mk(2'd1, M_MULTI,   0,   1, {2'd0, 2'd0, 2'd0, 2'd1}, 2'd0, 1, 3'd1);
        vecs[8] = mk(2'd3, M_NORMAL,  1,   3, {2'd0, 2'd3, 2'd2, 2'd1}, 2'd3, 0, 3'd3);

        // Reset with start held high: reset must win.
        rst    = 1'b1;
        start  = 1'b1;
        mode   = M_NORMAL;
        hidden = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst   = 1'b0;
        start = 1'b0;

        foreach (vecs[i]) run_search(i, vecs[i]);

        // Reset during the second probe of hidden=3 aborts the search.
        mode   = M_NORMAL;
        hidden = 2'd3;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 * PC - 1) @(posedge clk);
        #1;
        check("abort_second_guess", 32'(guess), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("abort");
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_stays_idle", 32'(busy), 0);

        // Recovery after the abort.
        run_search(9, mk(2'd2, M_NORMAL, 0, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 2'd2, 0, 3'd2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
